// File: rtl/vec_wb_pkg.sv
// Shared definitions for the vector write-back router: select encodings, FSM state type
// and default parameter values.
package vec_wb_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 4;

    localparam logic [1:0] SEL_VV         = 2'b00;
    localparam logic [1:0] SEL_VS_REG     = 2'b01;
    localparam logic [1:0] SEL_VS_IMM_MEM = 2'b11;
    localparam logic [1:0] SEL_ILLEGAL    = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STORE = 1'b1
    } state_t;

endpackage

// File: rtl/wb_lane_serializer.sv
// Issues a captured vector to memory one lane per valid/ready handshake, starting at
// a base address that wraps modulo 2^ADDR_W.
module wb_lane_serializer #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int ADDR_W = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_load,
    input  logic [ADDR_W-1:0]        i_base,
    input  logic [LANES*WIDTH-1:0]   i_data,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [WIDTH-1:0]         o_wdata,
    output logic                     o_last_hs
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                   r_active;
    logic [IDX_W-1:0]       r_idx;
    logic [ADDR_W-1:0]      r_base;
    logic [LANES*WIDTH-1:0] r_data;

    logic w_hs;
    logic w_last;

    assign w_hs   = r_active && i_ready;
    assign w_last = (r_idx == IDX_W'(LANES - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_base   <= '0;
            r_data   <= '0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_idx    <= '0;
            r_base   <= i_base;
            r_data   <= i_data;
        end else if (w_hs) begin
            if (w_last) begin
                r_active <= 1'b0;
                r_idx    <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Outputs are forced to zero whenever no lane is being offered.
    assign o_valid   = r_active;
    assign o_addr    = r_active ? (r_base + ADDR_W'(r_idx)) : '0;
    assign o_wdata   = r_active ? r_data[r_idx*WIDTH +: WIDTH] : '0;
    assign o_last_hs = w_hs && w_last;

endmodule

// File: rtl/vec_wb_router.sv
// Routes a vector result to the vector register file, scalar register file or a lane-serial
// memory store; illegal selects pulse sel_err. Optional error counter: VEC_WB_ERR_CNT_EN.
module vec_wb_router
    import vec_wb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             sel,
    input  logic [ADDR_W-1:0]      in_dst,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   vrf_we,
    output logic [ADDR_W-1:0]      vrf_waddr,
    output logic [LANES*WIDTH-1:0] vrf_wdata,
    output logic                   srf_we,
    output logic [ADDR_W-1:0]      srf_waddr,
    output logic [WIDTH-1:0]       srf_wdata,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [WIDTH-1:0]       mem_wdata,
    output logic                   sel_err
`ifdef VEC_WB_ERR_CNT_EN
    ,
    output logic [7:0]             err_cnt
`endif
);

    state_t r_state;
    state_t w_next_state;

    logic w_accept;
    logic w_last_hs;
    logic w_load;

    logic                   r_vrf_we;
    logic [ADDR_W-1:0]      r_vrf_waddr;
    logic [LANES*WIDTH-1:0] r_vrf_wdata;
    logic                   r_srf_we;
    logic [ADDR_W-1:0]      r_srf_waddr;
    logic [WIDTH-1:0]       r_srf_wdata;
    logic                   r_sel_err;

    assign in_ready = (r_state == ST_IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && (sel == SEL_VS_IMM_MEM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_load)    w_next_state = ST_STORE;
            ST_STORE: if (w_last_hs) w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // Register-file writes and the error pulse appear the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vrf_we    <= 1'b0;
            r_vrf_waddr <= '0;
            r_vrf_wdata <= '0;
            r_srf_we    <= 1'b0;
            r_srf_waddr <= '0;
            r_srf_wdata <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_vrf_we  <= w_accept && (sel == SEL_VV);
            r_srf_we  <= w_accept && (sel == SEL_VS_REG);
            r_sel_err <= w_accept && (sel == SEL_ILLEGAL);
            if (w_accept && (sel == SEL_VV)) begin
                r_vrf_waddr <= in_dst;
                r_vrf_wdata <= in_data;
            end
            if (w_accept && (sel == SEL_VS_REG)) begin
                r_srf_waddr <= in_dst;
                r_srf_wdata <= in_data[WIDTH-1:0];
            end
        end
    end

    assign vrf_we    = r_vrf_we;
    assign vrf_waddr = r_vrf_waddr;
    assign vrf_wdata = r_vrf_wdata;
    assign srf_we    = r_srf_we;
    assign srf_waddr = r_srf_waddr;
    assign srf_wdata = r_srf_wdata;
    assign sel_err   = r_sel_err;

    wb_lane_serializer #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_lane_serializer (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_load    (w_load),
        .i_base    (in_dst),
        .i_data    (in_data),
        .i_ready   (mem_ready),
        .o_valid   (mem_valid),
        .o_addr    (mem_addr),
        .o_wdata   (mem_wdata),
        .o_last_hs (w_last_hs)
    );

`ifdef VEC_WB_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_sel_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_vec_wb_router.sv
// Scoreboard bench for vec_wb_router: register writes, lane stores with stalls, illegal
// selects, reset during a store and random traffic.
module tb_vec_wb_router;
    import vec_wb_pkg::*;

    localparam int WIDTH  = 8;
    localparam int LANES  = 4;
    localparam int ADDR_W = 4;
    localparam int DW     = LANES * WIDTH;
    localparam int EW     = 2 + ADDR_W + DW;

    localparam logic [1:0] K_VRF = 2'd0;
    localparam logic [1:0] K_SRF = 2'd1;
    localparam logic [1:0] K_MEM = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] in_dst;
    logic [DW-1:0]     in_data;
    logic              vrf_we;
    logic [ADDR_W-1:0] vrf_waddr;
    logic [DW-1:0]     vrf_wdata;
    logic              srf_we;
    logic [ADDR_W-1:0] srf_waddr;
    logic [WIDTH-1:0]  srf_wdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              sel_err;
`ifdef VEC_WB_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    vec_wb_router #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in_dst    (in_dst),
        .in_data   (in_data),
        .vrf_we    (vrf_we),
        .vrf_waddr (vrf_waddr),
        .vrf_wdata (vrf_wdata),
        .srf_we    (srf_we),
        .srf_waddr (srf_waddr),
        .srf_wdata (srf_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .sel_err   (sel_err)
`ifdef VEC_WB_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [1:0] k, input logic [ADDR_W-1:0] a,
                                          input logic [DW-1:0] d);
        return {k, a, d};
    endfunction

    // Scoreboard monitor: every write strobe or memory handshake pops one expected entry.
    int hs_cnt = 0;
    int last_hs_cyc = 0;
    logic prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [WIDTH-1:0]  prev_data = '0;

    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic ev;
        int nstb;
        if (rst_n) begin
            nstb = int'(vrf_we) + int'(srf_we) + int'(mem_valid) + int'(sel_err);
            chk("exclusive", EW'(nstb <= 1), EW'(1));
            ev  = 1'b1;
            obs = '0;
            if (vrf_we)                      obs = ent(K_VRF, vrf_waddr, vrf_wdata);
            else if (srf_we)                 obs = ent(K_SRF, srf_waddr, DW'(srf_wdata));
            else if (mem_valid && mem_ready) obs = ent(K_MEM, mem_addr, DW'(mem_wdata));
            else if (sel_err)                obs = ent(K_ERR, '0, '0);
            else                             ev = 1'b0;
            if (ev) begin
                chk("sb_has_entry", EW'(exp_q.size() != 0), EW'(1));
                if (exp_q.size() != 0) chk("sb_data", obs, exp_q.pop_front());
            end
            if (mem_valid) chk("in_ready_in_store", EW'(in_ready), EW'(0));
            if (prev_stall) begin
                chk("stall_valid", EW'(mem_valid), EW'(1));
                chk("stall_addr", EW'(mem_addr), EW'(prev_addr));
                chk("stall_data", EW'(mem_wdata), EW'(prev_data));
            end
            if (mem_valid && mem_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            prev_stall = mem_valid && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Driver: present one result, wait for acceptance, push the expected outcome.
    task automatic send(input logic [1:0] s, input logic [ADDR_W-1:0] d, input logic [DW-1:0] data,
                        output int acc);
        int waited;
        logic ok;
        waited   = 0;
        ok       = 1'b0;
        acc      = -1;
        sel      = s;
        in_dst   = d;
        in_data  = data;
        in_valid = 1'b1;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (in_ready) begin
                ok  = 1'b1;
                acc = cyc;
                case (s)
                    SEL_VV:     exp_q.push_back(ent(K_VRF, d, data));
                    SEL_VS_REG: exp_q.push_back(ent(K_SRF, d, {{(DW-WIDTH){1'b0}}, data[WIDTH-1:0]}));
                    SEL_ILLEGAL: exp_q.push_back(ent(K_ERR, '0, '0));
                    default: begin
                        for (int i = 0; i < LANES; i++)
                            exp_q.push_back(ent(K_MEM, d + ADDR_W'(i),
                                                {{(DW-WIDTH){1'b0}}, data[i*WIDTH +: WIDTH]}));
                    end
                endcase
            end
            @(posedge clk);
            waited++;
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("accept_timeout", EW'(0), EW'(1));
    endtask

    task automatic chk_outputs_zero();
        chk("rst_vrf_we",    EW'(vrf_we),    EW'(0));
        chk("rst_vrf_waddr", EW'(vrf_waddr), EW'(0));
        chk("rst_vrf_wdata", EW'(vrf_wdata), EW'(0));
        chk("rst_srf_we",    EW'(srf_we),    EW'(0));
        chk("rst_srf_waddr", EW'(srf_waddr), EW'(0));
        chk("rst_srf_wdata", EW'(srf_wdata), EW'(0));
        chk("rst_mem_valid", EW'(mem_valid), EW'(0));
        chk("rst_mem_addr",  EW'(mem_addr),  EW'(0));
        chk("rst_mem_wdata", EW'(mem_wdata), EW'(0));
        chk("rst_sel_err",   EW'(sel_err),   EW'(0));
    endtask

    initial begin
        int a;
        int a2;
        int h0;
        logic [1:0] s;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = 2'b00;
        in_dst    = '0;
        in_data   = '0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", EW'(in_ready), EW'(1));
        @(posedge clk);
        #1;

        // Two illegal selects back to back
        send(SEL_ILLEGAL, 4'd7, 32'hCAFEF00D, a);
        send(SEL_ILLEGAL, 4'd2, 32'h01020304, a2);
        chk("err_back_to_back", EW'(a2), EW'(a + 1));
        repeat (2) @(posedge clk);
`ifdef VEC_WB_ERR_CNT_EN
        @(negedge clk);
        chk("err_cnt", EW'(err_cnt), EW'(2));
        @(posedge clk);
`endif
        #1;

        // Vector and scalar register writes
        send(SEL_VV, 4'd3, 32'hDDCCBBAA, a);
        send(SEL_VS_REG, 4'd5, 32'h44332211, a2);
        chk("reg_back_to_back", EW'(a2), EW'(a + 1));
        repeat (3) @(posedge clk);
        #1;

        // Store with wrapping address, no back-pressure
        mem_ready = 1'b1;
        h0 = hs_cnt;
        send(SEL_VS_IMM_MEM, 4'd14, 32'h44332211, a);
        for (int k = 0; k < 20 && hs_cnt < h0 + LANES; k++) @(posedge clk);
        chk("store_lane_count", EW'(hs_cnt - h0), EW'(LANES));
        chk("store_consecutive", EW'(last_hs_cyc - a), EW'(LANES));
        @(negedge clk);
        chk("store_done_valid", EW'(mem_valid), EW'(0));
        chk("store_done_ready", EW'(in_ready), EW'(1));
        @(posedge clk);
        #1;

        // Store stalled on lane 1 with a register write waiting behind it
        h0 = hs_cnt;
        send(SEL_VS_IMM_MEM, 4'd14, 32'h44332211, a);
        fork
            begin
                @(posedge clk);
                #1 mem_ready = 1'b0;
                @(negedge clk);
                chk("stall_lane1_addr", EW'(mem_addr), EW'(15));
                chk("stall_lane1_data", EW'(mem_wdata), EW'(8'h22));
                repeat (3) @(posedge clk);
                #1 mem_ready = 1'b1;
            end
            send(SEL_VV, 4'd9, 32'h12345678, a2);
        join
        chk("vv_waits_for_store", EW'(hs_cnt - h0), EW'(LANES));
        chk("vv_after_last_lane", EW'(a2 > last_hs_cyc), EW'(1));
        repeat (3) @(posedge clk);
        #1;

        // Reset after the lane 1 handshake aborts the store
        mem_ready = 1'b1;
        h0 = hs_cnt;
        send(SEL_VS_IMM_MEM, 4'd2, 32'hA1B2C3D4, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1 mem_ready = 1'b1;
        @(negedge clk);
        chk("abort_valid", EW'(mem_valid), EW'(0));
        chk_outputs_zero();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", EW'(in_ready), EW'(1));
        chk("abort_lanes_issued", EW'(hs_cnt - h0), EW'(2));
        chk("abort_lanes_left", EW'(exp_q.size()), EW'(2));
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_more_lanes", EW'(mem_valid), EW'(0));
        end
        @(posedge clk);
        #1;

        // Random traffic
        for (int i = 0; i < 16; i++) begin
            s = 2'($urandom_range(0, 3));
            send(s, ADDR_W'($urandom_range(0, 15)), $urandom, a);
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        chk("sb_drained", EW'(exp_q.size()), EW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
